sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one SRAM data port between the instruction-fetch bus (I) and the data bus (D) of the core.
//  Sits upstream of the sub-word write converter.
//  Grants one master per transaction and holds the grant while the converter stalls (read-modify-write).
//  Alternates grants on contention so neither master starves; stalls the loser.
// PARAMETERS
//  ADDR_W    32  address width, both masters and memory side
//  DATA_W    32  data width; byteenable width = DATA_W/8
//  CNT_W     16  width of contention counter (saturating)
// PORTS
//  clk          in   1        core clock
//  rst_n        in   1        async active-low reset
//  i_addr       in   ADDR_W   I-bus address
//  i_read       in   1        I-bus read request (I never writes)
//  i_rdata      out  DATA_W   I-bus read data
//  i_stall      out  1        I-bus must hold request this cycle
//  d_addr       in   ADDR_W   D-bus address
//  d_be         in   DATA_W/8 D-bus byteenable
//  d_read       in   1        D-bus read request
//  d_write      in   1        D-bus write request
//  d_wdata      in   DATA_W   D-bus write data
//  d_rdata      out  DATA_W   D-bus read data
//  d_stall      out  1        D-bus must hold request this cycle
//  m_addr       out  ADDR_W   to converter: address
//  m_be         out  DATA_W/8 to converter: byteenable (4'b1111 for I)
//  m_read       out  1        to converter: read
//  m_write      out  1        to converter: write
//  m_wdata      out  DATA_W   to converter: write data
//  m_rdata      in   DATA_W   from converter/SRAM: read data
//  m_stall      in   1        converter busy (multi-cycle RMW)
//  conflict_cnt out  CNT_W    cycles both masters requested, saturating
// BEHAVIOUR
//  - Requests: req_i = i_read; req_d = d_read|d_write. d_read&d_write together is illegal; treat as write.
//  - State: IDLE, OWN_I, OWN_D (registered); last_grant reg (0=I,1=D).
//  - Reset values: state=IDLE, last_grant=I (D wins first conflict), conflict_cnt=0.
//  - Reset values: m_read=m_write=0, m_addr/m_be/m_wdata=0 when no owner.
//  - Owner select (combinational) in IDLE:
//    - only one req -> that master;
//    - both -> master != last_grant;
//    - none -> no owner, m_* zero.
//  - In OWN_x: owner fixed to x regardless of other requests.
//  - Mux: owner's addr/be/read/write/wdata drive m_*; m_rdata fans out to both *_rdata unmuxed.
//  - Stalls: owner_stall = m_stall; non-owner requester stall=1; idle master stall=0.
//  - Transitions, evaluated at posedge:
//    - IDLE -> OWN_x when owner x and m_stall=1;
//    - IDLE stays when m_stall=0 (single-cycle access completes);
//    - OWN_x -> IDLE when m_stall=0 (transaction done this cycle).
//    - last_grant <= owner on every completing cycle (owner valid & m_stall=0).
//  - Latency: uncontended word access completes in the request cycle (0 wait).
//  - Latency: sub-word write completes 1 cycle later (converter stall).
//  - Loser waits exactly the winner's transaction length.
//  - Owner may not drop its request while stalled. Arbiter does not check; bench asserts this as a protocol rule.
//  - conflict_cnt += 1 each cycle req_i&req_d, saturates at all-ones, no wrap.
//  - Reset mid-transaction: state->IDLE immediately (async); m_read/m_write drop same instant; no partial write is replayed.
// STRUCTURE
//  - Shared package sram_pkg: state encoding (ARB_IDLE/ARB_OWN_I/ARB_OWN_D), MASTER_I/MASTER_D constants, BE_FULL.
//  - Single module, no sub-modules; the converter is instantiated beside it by the SRAM top, not inside.
// TESTING
//  - Reset: rst_n=0 with both requesting -> m_read=m_write=0, i_stall=d_stall=1, conflict_cnt=0.
//  - I only: i_read=1 @0x100, m_stall=0 -> m_addr=0x100, m_be=4'hF, i_stall=0 same cycle, state stays IDLE.
//  - Conflict: i_read & d_read both held 4 cycles, m_stall=0 -> grants D,I,D,I; conflict_cnt=4.
//  - RMW hold: d_write be=4'b0001 with m_stall=1 for 1 cycle, i_read concurrently -> D owns 2 cycles, i_stall=1 both cycles, I granted 3rd cycle.
//  - Saturation: CNT_W=4, 20 contended cycles -> conflict_cnt=4'hF.
//  - Async reset asserted in OWN_D -> m_write=0 before next clk edge; after release first conflict grants D.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   arb_state_t : arbiter ownership state (idle, owned by I, owned by D)
//   master_t    : master identifier, also used as the last-grant record
//   BE_FULL     : full-word byteenable for a 32-bit data path
package sram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    MASTER_I = 1'b0,
    MASTER_D = 1'b1
  } master_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one SRAM data port between the instruction-fetch bus (I, read only)
// and the data bus (D). One master owns the port per transaction; ownership
// is held while the downstream sub-word converter stalls, and contended
// idle-state grants alternate so neither master starves.
//
// Ports
//   clk, rst_n                 core clock, async active-low reset
//   i_addr/i_read              I-bus request;  i_rdata/i_stall back to I
//   d_addr/d_be/d_read/d_write/d_wdata  D-bus request; d_rdata/d_stall back to D
//   m_addr/m_be/m_read/m_write/m_wdata  request to the converter
//   m_rdata, m_stall           read data and busy from the converter
//   conflict_cnt               saturating count of cycles both masters requested
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_read,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_be,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_stall,
  output logic [CNT_W-1:0]    conflict_cnt
);

  arb_state_t state;
  master_t    last_grant;
  master_t    owner;
  logic       owner_valid;
  logic       req_i;
  logic       req_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // Read data is shared; each master only consumes it when it owns the port.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Owner selection. Gated by rst_n so the memory-side strobes drop the
  // instant reset asserts, without waiting for the async state clear to
  // propagate through a clock edge.
  always_comb begin
    owner_valid = 1'b0;
    owner       = MASTER_I;
    if (rst_n) begin
      unique case (state)
        ARB_OWN_I: begin
          owner_valid = 1'b1;
          owner       = MASTER_I;
        end
        ARB_OWN_D: begin
          owner_valid = 1'b1;
          owner       = MASTER_D;
        end
        default: begin
          if (req_i && req_d) begin
            owner_valid = 1'b1;
            owner       = (last_grant == MASTER_I) ? MASTER_D : MASTER_I;
          end else if (req_d) begin
            owner_valid = 1'b1;
            owner       = MASTER_D;
          end else if (req_i) begin
            owner_valid = 1'b1;
            owner       = MASTER_I;
          end
        end
      endcase
    end
  end

  // Memory-side mux. A simultaneous D read+write is treated as a write.
  always_comb begin
    m_addr  = '0;
    m_be    = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_wdata = '0;
    if (owner_valid) begin
      if (owner == MASTER_D) begin
        m_addr  = d_addr;
        m_be    = d_be;
        m_read  = d_read & ~d_write;
        m_write = d_write;
        m_wdata = d_wdata;
      end else begin
        m_addr  = i_addr;
        m_be    = '1;
        m_read  = 1'b1;
      end
    end
  end

  // Owner sees the converter stall; a requesting non-owner always stalls.
  always_comb begin
    i_stall = req_i;
    d_stall = req_d;
    if (owner_valid && owner == MASTER_I) i_stall = m_stall;
    if (owner_valid && owner == MASTER_D) d_stall = m_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      last_grant   <= MASTER_I;
      conflict_cnt <= '0;
    end else begin
      if (owner_valid) begin
        if (m_stall) begin
          state <= (owner == MASTER_D) ? ARB_OWN_D : ARB_OWN_I;
        end else begin
          state      <= ARB_IDLE;
          last_grant <= owner;
        end
      end else begin
        state <= ARB_IDLE;
      end
      if (req_i && req_d && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written
// multi-cycle sequences (saturation, async reset), then randomized traffic
// against a transaction-level reference model.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_read;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_stall;
  logic [3:0]  conflict_cnt;

  int n_vec;
  int n_err;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_addr(d_addr), .d_be(d_be), .d_read(d_read), .d_write(d_write),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_addr(m_addr), .m_be(m_be), .m_read(m_read), .m_write(m_write),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_stall(m_stall),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_read;
    logic [31:0] i_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        m_stall;
    logic        e_read;
    logic        e_write;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_istall;
    logic        e_dstall;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [3:0] db, input logic [31:0] dwd, input logic ms,
                              input logic er, input logic ew, input logic [31:0] ea,
                              input logic [3:0] eb, input logic [31:0] ewd,
                              input logic eis, input logic eds, input logic [3:0] ec);
    vec_t v;
    v.i_read = ir; v.i_addr = ia; v.d_read = dr; v.d_write = dw; v.d_addr = da;
    v.d_be = db; v.d_wdata = dwd; v.m_stall = ms;
    v.e_read = er; v.e_write = ew; v.e_addr = ea; v.e_be = eb; v.e_wdata = ewd;
    v.e_istall = eis; v.e_dstall = eds; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [3:0] db,
                       input logic [31:0] dwd, input logic ms);
    i_read = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da;
    d_be = db; d_wdata = dwd; m_stall = ms;
  endtask

  task automatic check_outs(input string tag, input logic er, input logic ew,
                            input logic [31:0] ea, input logic [3:0] eb,
                            input logic [31:0] ewd, input logic eis,
                            input logic eds, input logic [3:0] ec);
    chk({tag, " m_read"},  32'(m_read),       32'(er));
    chk({tag, " m_write"}, 32'(m_write),      32'(ew));
    chk({tag, " m_addr"},  m_addr,            ea);
    chk({tag, " m_be"},    32'(m_be),         32'(eb));
    chk({tag, " m_wdata"}, m_wdata,           ewd);
    chk({tag, " i_stall"}, 32'(i_stall),      32'(eis));
    chk({tag, " d_stall"}, 32'(d_stall),      32'(eds));
    chk({tag, " cnt"},     32'(conflict_cnt), 32'(ec));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];

  // Reference model state (transaction level): -1 = no locked owner, 0 = I, 1 = D.
  int locked;
  int last;
  int cnt;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    m_rdata = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    // Reset with both masters requesting: no memory strobes, both stalled.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
    #1;
    check_outs("reset", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    //            ir  ia       dr dw da       db    wdata    ms   er ew ea       eb    ewd      is ds cnt
    tbl[0]  = mk(1, 32'h100, 0, 0, 32'h0,   4'h0, 32'h0,   0,   1, 0, 32'h100, 4'hF, 32'h0,   0, 0, 4'd0);
    tbl[1]  = mk(1, 32'h200, 1, 0, 32'h300, 4'hF, 32'h11,  0,   1, 0, 32'h300, 4'hF, 32'h11,  1, 0, 4'd0);
    tbl[2]  = mk(1, 32'h200, 1, 0, 32'h300, 4'hF, 32'h11,  0,   1, 0, 32'h200, 4'hF, 32'h0,   0, 1, 4'd1);
    tbl[3]  = mk(1, 32'h200, 1, 0, 32'h300, 4'hF, 32'h11,  0,   1, 0, 32'h300, 4'hF, 32'h11,  1, 0, 4'd2);
    tbl[4]  = mk(1, 32'h200, 1, 0, 32'h300, 4'hF, 32'h11,  0,   1, 0, 32'h200, 4'hF, 32'h0,   0, 1, 4'd3);
    tbl[5]  = mk(0, 32'h0,   0, 0, 32'h0,   4'h0, 32'h0,   0,   0, 0, 32'h0,   4'h0, 32'h0,   0, 0, 4'd4);
    tbl[6]  = mk(1, 32'h500, 0, 1, 32'h400, 4'h1, 32'hAB,  1,   0, 1, 32'h400, 4'h1, 32'hAB,  1, 1, 4'd4);
    tbl[7]  = mk(1, 32'h500, 0, 1, 32'h400, 4'h1, 32'hAB,  0,   0, 1, 32'h400, 4'h1, 32'hAB,  1, 0, 4'd5);
    tbl[8]  = mk(1, 32'h500, 0, 0, 32'h0,   4'h0, 32'h0,   0,   1, 0, 32'h500, 4'hF, 32'h0,   0, 0, 4'd6);
    tbl[9]  = mk(0, 32'h0,   1, 1, 32'h600, 4'hF, 32'h77,  0,   0, 1, 32'h600, 4'hF, 32'h77,  0, 0, 4'd6);
    tbl[10] = mk(1, 32'h700, 0, 0, 32'h0,   4'h0, 32'h0,   1,   1, 0, 32'h700, 4'hF, 32'h0,   1, 0, 4'd6);
    tbl[11] = mk(1, 32'h700, 1, 0, 32'h800, 4'h3, 32'h0,   0,   1, 0, 32'h700, 4'hF, 32'h0,   0, 1, 4'd6);
    tbl[12] = mk(0, 32'h0,   1, 0, 32'h800, 4'h3, 32'h0,   0,   1, 0, 32'h800, 4'h3, 32'h0,   0, 0, 4'd7);

    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      drive(tbl[k].i_read, tbl[k].i_addr, tbl[k].d_read, tbl[k].d_write,
            tbl[k].d_addr, tbl[k].d_be, tbl[k].d_wdata, tbl[k].m_stall);
      #1;
      check_outs($sformatf("v%0d", k), tbl[k].e_read, tbl[k].e_write, tbl[k].e_addr,
                 tbl[k].e_be, tbl[k].e_wdata, tbl[k].e_istall, tbl[k].e_dstall,
                 tbl[k].e_cnt);
    end

    // Saturation: 20 contended cycles on top of 7 earlier conflicts.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 4'hF, 32'h0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    #1;
    chk("sat cnt", 32'(conflict_cnt), 32'hF);
    @(negedge clk);
    #1;
    chk("sat hold", 32'(conflict_cnt), 32'hF);

    // Async reset while D owns the port in a stalled RMW write.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 4'h1, 32'h55, 1'b1);
    #1;
    chk("rmw m_write", 32'(m_write), 32'h1);
    @(posedge clk);
    #2;
    i_read = 1'b1;
    i_addr = 32'hA00;
    #1;
    chk("own_d m_addr", m_addr, 32'h900);
    chk("own_d i_stall", 32'(i_stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst m_write", 32'(m_write), 32'h0);
    chk("arst m_read", 32'(m_read), 32'h0);
    chk("arst d_stall", 32'(d_stall), 32'h1);
    chk("arst cnt", 32'(conflict_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hA00, 1'b1, 1'b0, 32'hB00, 4'hF, 32'h0, 1'b0);
    #1;
    chk("post-rst grant addr", m_addr, 32'hB00);
    chk("post-rst i_stall", 32'(i_stall), 32'h1);
    chk("post-rst d_stall", 32'(d_stall), 32'h0);

    // Randomized traffic against the reference model.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    do_reset();
    locked = -1;
    last   = 0;
    cnt    = 0;
    begin
      logic hold_i, hold_d;
      hold_i = 1'b0;
      hold_d = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        int own;
        logic ri, rd, er, ew, eis, eds;
        logic [31:0] ea, ewd;
        logic [3:0] eb;
        @(negedge clk);
        // Stalled masters keep their request stable.
        if (!hold_i) begin
          i_read = 1'($urandom_range(0, 1));
          i_addr = $urandom;
        end
        if (!hold_d) begin
          int sel;
          sel = int'($urandom_range(0, 3));
          d_read  = (sel == 1);
          d_write = (sel >= 2);
          d_addr  = $urandom;
          d_be    = (sel == 3) ? 4'($urandom_range(1, 14)) : 4'hF;
          d_wdata = $urandom;
        end
        m_stall = ($urandom_range(0, 3) == 0);
        m_rdata = $urandom;
        ri = i_read;
        rd = d_read | d_write;
        if (locked == 0) assert (ri) else $error("FAIL protocol: I dropped request while owning");
        if (locked == 1) assert (rd) else $error("FAIL protocol: D dropped request while owning");

        if (locked >= 0)   own = locked;
        else if (ri && rd) own = 1 - last;
        else if (rd)       own = 1;
        else if (ri)       own = 0;
        else               own = -1;

        er = 1'b0; ew = 1'b0; ea = 32'h0; eb = 4'h0; ewd = 32'h0;
        if (own == 1) begin
          er = d_read & ~d_write; ew = d_write; ea = d_addr; eb = d_be; ewd = d_wdata;
        end else if (own == 0) begin
          er = 1'b1; ea = i_addr; eb = 4'hF;
        end
        eis = ri && !(own == 0 && !m_stall);
        eds = rd && !(own == 1 && !m_stall);
        #1;
        check_outs($sformatf("rnd%0d", c), er, ew, ea, eb, ewd, eis, eds, 4'(cnt));
        chk($sformatf("rnd%0d i_rdata", c), i_rdata, m_rdata);
        chk($sformatf("rnd%0d d_rdata", c), d_rdata, m_rdata);

        if (own >= 0) begin
          if (m_stall) locked = own;
          else begin
            locked = -1;
            last   = own;
          end
        end else begin
          locked = -1;
        end
        if (ri && rd && cnt < 15) cnt++;
        hold_i = eis;
        hold_d = eds;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
